// File: rtl/dac_mcp4921_pkg.sv
// Shared definitions for the MCP4921 DAC driver: FSM encoding and frame layout.
package dac_mcp4921_pkg;

    localparam int unsigned FRAME_BITS = 16;

    // Command nibble bit positions inside the 16-bit SPI frame
    localparam int unsigned BIT_AB     = 15;
    localparam int unsigned BIT_BUF    = 14;
    localparam int unsigned BIT_GA_N   = 13;
    localparam int unsigned BIT_SHDN_N = 12;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StShift  = 3'd2,
        StCsHold = 3'd3,
        StLdac   = 3'd4
    } state_e;

    // Assemble the write command for channel A
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic        buf_en,
        input logic        ga_n,
        input logic        shdn,
        input logic [11:0] code
    );
        logic [FRAME_BITS-1:0] f;
        f             = '0;
        f[BIT_AB]     = 1'b0;
        f[BIT_BUF]    = buf_en;
        f[BIT_GA_N]   = ga_n;
        f[BIT_SHDN_N] = ~shdn;
        f[11:0]       = code;
        return f;
    endfunction

endpackage

// File: rtl/dac_mcp4921_edge_detect.sv
// Two-register rising-edge detector; emits a one-cycle pulse per rising edge.
module dac_mcp4921_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q1;
    logic sig_q2;

    // Sample the input twice; the pair also acts as a synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q1 <= 1'b0;
            sig_q2 <= 1'b0;
        end else begin
            sig_q1 <= sig;
            sig_q2 <= sig_q1;
        end
    end

    assign rise = sig_q1 & ~sig_q2;

endmodule

// File: rtl/dac_mcp4921.sv
// MCP4921 12-bit SPI DAC driver: one write frame plus LDAC strobe per LATCH edge.
module dac_mcp4921
    import dac_mcp4921_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25,
    parameter bit          GAIN_1X = 1'b1,
    parameter bit          BUF     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        latch,
    input  logic [11:0] value,
    input  logic        shdn,
    output logic        cs_dac,
    output logic        clk_dac,
    output logic        sdi_dac,
    output logic        ldac_n,
    output logic        busy
);

    localparam logic [15:0] HALF = 16'(CLK_DIV);

    state_e                 state;
    logic [15:0]            hp_cnt;
    logic [4:0]             bit_cnt;
    logic [FRAME_BITS-2:0]  shreg;   // bits still to send after the MSB
    logic [FRAME_BITS-1:0]  frame;
    logic                   start;
    logic                   tick;

    dac_mcp4921_edge_detect u_latch_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (latch),
        .rise  (start)
    );

    assign frame = build_frame(BUF, GAIN_1X, shdn, value);
    assign tick  = (hp_cnt == HALF);

    // Frame sequencer; every output is a register so the SPI pins are glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            hp_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            cs_dac  <= 1'b1;
            clk_dac <= 1'b0;
            sdi_dac <= 1'b0;
            ldac_n  <= 1'b1;
            busy    <= 1'b0;
        end else begin
            // Half-period counter runs whenever a frame is in flight
            if (state != StIdle) begin
                hp_cnt <= tick ? 16'd1 : hp_cnt + 16'd1;
            end
            case (state)
                StIdle: begin
                    if (start) begin
                        shreg   <= frame[FRAME_BITS-2:0];
                        sdi_dac <= frame[FRAME_BITS-1];
                        cs_dac  <= 1'b0;
                        busy    <= 1'b1;
                        hp_cnt  <= 16'd1;
                        bit_cnt <= '0;
                        state   <= StSetup;
                    end
                end
                StSetup: begin
                    if (tick) begin
                        clk_dac <= 1'b1;
                        state   <= StShift;
                    end
                end
                StShift: begin
                    if (tick) begin
                        if (clk_dac) begin
                            clk_dac <= 1'b0;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd15) begin
                                state <= StCsHold;
                            end else begin
                                // Next bit goes out on the falling edge
                                sdi_dac <= shreg[FRAME_BITS-2];
                                shreg   <= {shreg[FRAME_BITS-3:0], 1'b0};
                            end
                        end else begin
                            clk_dac <= 1'b1;
                        end
                    end
                end
                StCsHold: begin
                    if (tick) begin
                        cs_dac  <= 1'b1;
                        sdi_dac <= 1'b0;
                        state   <= StLdac;
                    end
                end
                StLdac: begin
                    // One T of CS-high gap, then one T of LDAC low
                    if (tick) begin
                        if (ldac_n) begin
                            ldac_n <= 1'b0;
                        end else begin
                            ldac_n  <= 1'b1;
                            busy    <= 1'b0;
                            hp_cnt  <= '0;
                            bit_cnt <= '0;
                            shreg   <= '0;
                            state   <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_mcp4921.sv
// Self-checking bench for dac_mcp4921: three instances with different configurations.
module tb_dac_mcp4921;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  latch;
    logic [11:0] value;
    logic        shdn;
    logic [2:0]  cs, sck, sdi, ldac, busy;
    logic        mon_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [15:0] word;
        int          rises;
        int          falls;
        int          rise_sum;
        int          fall_sum;
        int          first_rise;
        int          last_fall;
        int          cs_len;
        int          busy_len;
        int          ldac_len;
        int          ldac_start;
        int          sdi_bad;
        int          starts;
        int          pulses;
    } mon_t;

    // Instance 0: defaults (T=25); 1: T=1; 2: T=3, 2x gain, buffered VREF
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int unsigned DIV = (g == 0) ? 25 : ((g == 1) ? 1 : 3);
        localparam bit          GA  = (g == 2) ? 1'b0 : 1'b1;
        localparam bit          BF  = (g == 2) ? 1'b1 : 1'b0;

        dac_mcp4921 #(
            .CLK_DIV (DIV),
            .GAIN_1X (GA),
            .BUF     (BF)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .latch   (latch[g]),
            .value   (value),
            .shdn    (shdn),
            .cs_dac  (cs[g]),
            .clk_dac (sck[g]),
            .sdi_dac (sdi[g]),
            .ldac_n  (ldac[g]),
            .busy    (busy[g])
        );

        mon_t m;
        logic p_busy, p_cs, p_sck, p_sdi, p_ldac;

        // Pin-level observer; index t counts cycles since CS fell
        always @(negedge clk) begin
            if (mon_clr) begin
                m.t <= 0; m.word <= '0; m.rises <= 0; m.falls <= 0;
                m.rise_sum <= 0; m.fall_sum <= 0; m.first_rise <= -1; m.last_fall <= -1;
                m.cs_len <= 0; m.busy_len <= 0; m.ldac_len <= 0; m.ldac_start <= -1;
                m.sdi_bad <= 0; m.starts <= 0; m.pulses <= 0;
                p_busy <= 1'b0; p_cs <= 1'b1; p_sck <= 1'b0; p_sdi <= 1'b0; p_ldac <= 1'b1;
            end else begin
                if (busy[g] && !p_busy) begin
                    m.starts <= m.starts + 1;
                    m.t <= 0; m.word <= '0; m.rises <= 0; m.falls <= 0;
                    m.rise_sum <= 0; m.fall_sum <= 0; m.first_rise <= -1; m.last_fall <= -1;
                    m.cs_len <= cs[g] ? 0 : 1; m.busy_len <= 1; m.ldac_len <= 0;
                    m.ldac_start <= -1; m.sdi_bad <= 0;
                end else begin
                    m.t <= m.t + 1;
                    m.busy_len <= m.busy_len + (busy[g] ? 1 : 0);
                    m.cs_len <= m.cs_len + (cs[g] ? 0 : 1);
                    if (!ldac[g]) begin
                        m.ldac_len <= m.ldac_len + 1;
                        if (p_ldac) m.ldac_start <= m.t + 1;
                    end
                    if (ldac[g] && !p_ldac) m.pulses <= m.pulses + 1;
                    if (sck[g] && !p_sck) begin
                        m.word <= {m.word[14:0], sdi[g]};
                        m.rises <= m.rises + 1;
                        m.rise_sum <= m.rise_sum + m.t + 1;
                        if (m.first_rise < 0) m.first_rise <= m.t + 1;
                    end
                    if (!sck[g] && p_sck) begin
                        m.falls <= m.falls + 1;
                        m.fall_sum <= m.fall_sum + m.t + 1;
                        m.last_fall <= m.t + 1;
                    end
                    if (sdi[g] != p_sdi && !(p_sck && !sck[g]) && !(cs[g] && !p_cs))
                        m.sdi_bad <= m.sdi_bad + 1;
                end
                p_busy <= busy[g]; p_cs <= cs[g]; p_sck <= sck[g];
                p_sdi <= sdi[g]; p_ldac <= ldac[g];
            end
        end
    end

    function automatic int div_of(input int g);
        return (g == 0) ? 25 : ((g == 1) ? 1 : 3);
    endfunction

    // Expected frame from the device command format
    function automatic logic [15:0] model_frame(input int g, input logic [11:0] v, input logic sd);
        int f;
        f = int'(v);
        if (!sd) f += 4096;
        if (g != 2) f += 8192;
        if (g == 2) f += 16384;
        return f[15:0];
    endfunction

    task automatic snap(input int g, output mon_t s);
        case (g)
            0: s = gen_dut[0].m;
            1: s = gen_dut[1].m;
            default: s = gen_dut[2].m;
        endcase
    endtask

    task automatic pulse_latch(input int g);
        @(negedge clk);
        latch[g] = 1'b1;
        repeat (3) @(negedge clk);
        latch[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int budget);
        int n;
        n = 0;
        while (busy[g] === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy[g] !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle dut%0d: busy=%b after %0d cycles, required 0", g, busy[g], n);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        latch[0] = 1'b1;
        repeat (3) @(negedge clk);
        latch[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cs !== 3'b111) begin errors++; $display("FAIL reset_cs: got %b required 111", cs); end
        checks++; if (sck !== 3'b000) begin errors++; $display("FAIL reset_sck: got %b required 000", sck); end
        checks++; if (sdi !== 3'b000) begin errors++; $display("FAIL reset_sdi: got %b required 000", sdi); end
        checks++; if (ldac !== 3'b111) begin errors++; $display("FAIL reset_ldac: got %b required 111", ldac); end
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b required 000", busy); end
    endtask

    task automatic test_basic();
        mon_t s0, s;
        int   tt;
        tt = div_of(0);
        snap(0, s0);
        value = 12'hABC; shdn = 1'b0;
        pulse_latch(0);
        wait_idle(0, 40 * tt);
        snap(0, s);
        checks++; if (s.word !== 16'h3ABC) begin errors++; $display("FAIL basic_word: got %h required 3abc", s.word); end
        checks++; if (s.rises != 16) begin errors++; $display("FAIL basic_rises: got %0d required 16", s.rises); end
        checks++; if (s.falls != 16) begin errors++; $display("FAIL basic_falls: got %0d required 16", s.falls); end
        checks++; if (s.first_rise != tt) begin errors++; $display("FAIL basic_first_rise: got %0d required %0d", s.first_rise, tt); end
        checks++; if (s.rise_sum != 256 * tt) begin errors++; $display("FAIL basic_rise_times: got %0d required %0d", s.rise_sum, 256 * tt); end
        checks++; if (s.fall_sum != 272 * tt) begin errors++; $display("FAIL basic_fall_times: got %0d required %0d", s.fall_sum, 272 * tt); end
        checks++; if (s.last_fall != 32 * tt) begin errors++; $display("FAIL basic_last_fall: got %0d required %0d", s.last_fall, 32 * tt); end
        checks++; if (s.cs_len != 825) begin errors++; $display("FAIL basic_cs_low: got %0d required 825", s.cs_len); end
        checks++; if (s.ldac_len != 25) begin errors++; $display("FAIL basic_ldac_low: got %0d required 25", s.ldac_len); end
        checks++; if (s.ldac_start - s.last_fall != 50) begin errors++; $display("FAIL basic_ldac_gap: got %0d required 50", s.ldac_start - s.last_fall); end
        checks++; if (s.busy_len != 875) begin errors++; $display("FAIL basic_busy_len: got %0d required 875", s.busy_len); end
        checks++; if (s.sdi_bad != 0) begin errors++; $display("FAIL basic_sdi_stable: got %0d stray changes required 0", s.sdi_bad); end
        checks++; if (s.pulses - s0.pulses != 1) begin errors++; $display("FAIL basic_ldac_pulses: got %0d required 1", s.pulses - s0.pulses); end
    endtask

    task automatic test_config();
        mon_t s;
        logic [15:0] exp;
        value = 12'h000; shdn = 1'b1;
        exp = model_frame(2, value, shdn);
        pulse_latch(2);
        wait_idle(2, 40 * div_of(2));
        snap(2, s);
        checks++; if (s.word !== exp) begin errors++; $display("FAIL config_word: got %h required %h", s.word, exp); end
        checks++; if (s.word !== 16'h4000) begin errors++; $display("FAIL config_word_const: got %h required 4000", s.word); end
        checks++; if (s.rises != 16) begin errors++; $display("FAIL config_rises: got %0d required 16", s.rises); end
        checks++; if (s.busy_len != 35 * 3) begin errors++; $display("FAIL config_busy_len: got %0d required 105", s.busy_len); end
    endtask

    task automatic test_fast();
        mon_t s;
        value = 12'hFFF; shdn = 1'b0;
        pulse_latch(1);
        wait_idle(1, 60);
        snap(1, s);
        checks++; if (s.word !== 16'h3FFF) begin errors++; $display("FAIL fast_word: got %h required 3fff", s.word); end
        checks++; if (s.rises != 16) begin errors++; $display("FAIL fast_rises: got %0d required 16", s.rises); end
        checks++; if (s.busy_len != 35) begin errors++; $display("FAIL fast_busy_len: got %0d required 35", s.busy_len); end
        checks++; if (s.cs_len != 33) begin errors++; $display("FAIL fast_cs_low: got %0d required 33", s.cs_len); end
        checks++; if (s.ldac_len != 1) begin errors++; $display("FAIL fast_ldac_low: got %0d required 1", s.ldac_len); end
        checks++; if (s.sdi_bad != 0) begin errors++; $display("FAIL fast_sdi_stable: got %0d required 0", s.sdi_bad); end
    endtask

    task automatic test_ignore();
        mon_t s0, s;
        snap(0, s0);
        value = 12'hABC; shdn = 1'b0;
        pulse_latch(0);
        repeat (248) @(negedge clk);
        value = 12'h123;
        latch[0] = 1'b1;
        repeat (3) @(negedge clk);
        latch[0] = 1'b0;
        wait_idle(0, 40 * div_of(0));
        repeat (100) @(negedge clk);
        #1;
        snap(0, s);
        checks++; if (s.word !== 16'h3ABC) begin errors++; $display("FAIL ignore_word: got %h required 3abc", s.word); end
        checks++; if (s.starts - s0.starts != 1) begin errors++; $display("FAIL ignore_starts: got %0d required 1", s.starts - s0.starts); end
        checks++; if (s.pulses - s0.pulses != 1) begin errors++; $display("FAIL ignore_pulses: got %0d required 1", s.pulses - s0.pulses); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %b required 0", busy[0]); end
    endtask

    task automatic test_back_to_back();
        mon_t s0, s;
        logic [15:0] exp;
        value = 12'($urandom); shdn = 1'($urandom_range(0, 1));
        exp = model_frame(1, value, shdn);
        // Second edge lands on the cycle busy falls: dropped
        snap(1, s0);
        @(negedge clk); latch[1] = 1'b1;
        repeat (3) @(negedge clk); latch[1] = 1'b0;
        repeat (32) @(negedge clk); latch[1] = 1'b1;
        @(negedge clk);
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL b2b_late_busy: got %b required 1", busy[1]); end
        @(negedge clk);
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL b2b_drop_busy0: got %b required 0", busy[1]); end
        @(negedge clk); latch[1] = 1'b0;
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL b2b_drop_busy1: got %b required 0", busy[1]); end
        repeat (20) @(negedge clk);
        #1;
        snap(1, s);
        checks++; if (s.starts - s0.starts != 1) begin errors++; $display("FAIL b2b_drop_starts: got %0d required 1", s.starts - s0.starts); end
        // One cycle later: accepted, restarts immediately after idle
        snap(1, s0);
        @(negedge clk); latch[1] = 1'b1;
        repeat (3) @(negedge clk); latch[1] = 1'b0;
        repeat (33) @(negedge clk); latch[1] = 1'b1;
        @(negedge clk);
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy0: got %b required 0", busy[1]); end
        @(negedge clk); latch[1] = 1'b0;
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL b2b_gap_busy1: got %b required 1", busy[1]); end
        wait_idle(1, 60);
        snap(1, s);
        checks++; if (s.starts - s0.starts != 2) begin errors++; $display("FAIL b2b_accept_starts: got %0d required 2", s.starts - s0.starts); end
        checks++; if (s.pulses - s0.pulses != 2) begin errors++; $display("FAIL b2b_accept_pulses: got %0d required 2", s.pulses - s0.pulses); end
        checks++; if (s.word !== exp) begin errors++; $display("FAIL b2b_word: got %h required %h", s.word, exp); end
    endtask

    task automatic test_reset_mid();
        mon_t s0, s;
        logic [15:0] exp;
        snap(0, s0);
        value = 12'h5A5; shdn = 1'b0;
        pulse_latch(0);
        repeat (498) @(negedge clk);
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b required 1", busy[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cs[0] !== 1'b1) begin errors++; $display("FAIL rstmid_cs: got %b required 1", cs[0]); end
        checks++; if (sck[0] !== 1'b0) begin errors++; $display("FAIL rstmid_sck: got %b required 0", sck[0]); end
        checks++; if (sdi[0] !== 1'b0) begin errors++; $display("FAIL rstmid_sdi: got %b required 0", sdi[0]); end
        checks++; if (ldac[0] !== 1'b1) begin errors++; $display("FAIL rstmid_ldac: got %b required 1", ldac[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy[0]); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        snap(0, s);
        checks++; if (s.pulses != s0.pulses) begin errors++; $display("FAIL rstmid_no_ldac: got %0d pulses required %0d", s.pulses, s0.pulses); end
        checks++; if (s.starts - s0.starts != 1) begin errors++; $display("FAIL rstmid_no_restart: got %0d required 1", s.starts - s0.starts); end
        value = 12'h2C7; shdn = 1'b0;
        exp = model_frame(0, value, shdn);
        snap(0, s0);
        pulse_latch(0);
        wait_idle(0, 40 * div_of(0));
        snap(0, s);
        checks++; if (s.word !== exp) begin errors++; $display("FAIL rstmid_after_word: got %h required %h", s.word, exp); end
        checks++; if (s.pulses - s0.pulses != 1) begin errors++; $display("FAIL rstmid_after_ldac: got %0d required 1", s.pulses - s0.pulses); end
    endtask

    task automatic test_random();
        mon_t s;
        logic [15:0] exp;
        int g;
        for (int i = 0; i < 8; i++) begin
            g = 1 + (i % 2);
            value = 12'($urandom);
            shdn = 1'($urandom_range(0, 1));
            exp = model_frame(g, value, shdn);
            pulse_latch(g);
            // Inputs wander mid-frame; the captured frame must not
            value = 12'($urandom);
            shdn = 1'($urandom_range(0, 1));
            wait_idle(g, 40 * div_of(g));
            snap(g, s);
            checks++; if (s.word !== exp) begin errors++; $display("FAIL rand%0d_word: got %h required %h", i, s.word, exp); end
            checks++; if (s.rises != 16) begin errors++; $display("FAIL rand%0d_rises: got %0d required 16", i, s.rises); end
            checks++; if (s.busy_len != 35 * div_of(g)) begin errors++; $display("FAIL rand%0d_busy_len: got %0d required %0d", i, s.busy_len, 35 * div_of(g)); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        latch   = 3'b000;
        value   = 12'h000;
        shdn    = 1'b0;
        mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        mon_clr = 1'b0;
        repeat (3) @(negedge clk);
        test_basic();
        test_config();
        test_fast();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_mcp4921.md
DAC_MCP4921 -- requirements
Module: DAC_MCP4921

Interface
REQ-001 Parameter CLK_DIV, default 25, SHALL set the SPI half-period T in CLK cycles (legal range 1..65535).
REQ-002 Parameter GAIN_1X, default 1, SHALL drive frame bit 13 (GA_N: 1 = 1x gain, 0 = 2x gain).
REQ-003 Parameter BUF, default 0, SHALL drive frame bit 14 (VREF buffer enable).
REQ-004 CLK  input  1  system clock; all state changes occur on its rising edge.
REQ-005 RST_N  input  1  reset, asynchronous and active-low.
REQ-006 LATCH  input  1  start request; its rising edge starts one DAC update.
REQ-007 VALUE  input  12  DAC code, captured at frame start.
REQ-008 SHDN  input  1  shutdown request, captured at frame start; 1 SHALL clear frame bit 12 (SHDN_N).
REQ-009 CS_DAC  output  1  SPI chip select, active-low.
REQ-010 CLK_DAC  output  1  SPI clock, idles low.
REQ-011 SDI_DAC  output  1  SPI data to DAC, MSB first.
REQ-012 LDAC_N  output  1  DAC output-latch strobe, active-low.
REQ-013 BUSY  output  1  high from frame start until the LDAC pulse ends.

Function
REQ-014 LATCH SHALL pass through two registers; start = first register high and second register low, giving a 1-cycle pulse per rising edge.
REQ-015 Frame SHALL be {1'b0 (DAC A), BUF, GAIN_1X, !SHDN, VALUE[11:0]}, sent bit 15 first.
REQ-016 FSM states: IDLE, SETUP, SHIFT, CS_HOLD, LDAC. The FSM SHALL visit them in this order and then return to IDLE.
REQ-017 IDLE: CS_DAC=1, CLK_DAC=0, SDI_DAC=0, LDAC_N=1, BUSY=0. On start: capture the frame, set CS_DAC=0, SDI_DAC=frame[15] and BUSY=1, then enter SETUP.
REQ-018 Timing is counted in T from the cycle CS_DAC falls (t=0). CLK_DAC SHALL rise at T, 3T, ..., 31T and fall at 2T, 4T, ..., 32T.
REQ-019 SDI_DAC SHALL advance to the next bit on the same cycle CLK_DAC falls. It SHALL be stable for T before and T after each rising edge.
REQ-020 After the 16th falling edge (32T), CS_DAC SHALL stay low for T and go high at 33T (CS_HOLD). SDI_DAC SHALL return to 0 at 33T.
REQ-021 LDAC_N SHALL be low from 34T to 35T. BUSY SHALL fall at 35T, and the FSM SHALL re-enter IDLE at 35T.
REQ-022 The half-period counter SHALL be 16 bits and reload to 1 at each T boundary. The bit counter SHALL be 5 bits, counting 0..16.
REQ-023 A LATCH edge while BUSY=1 SHALL be ignored (not queued). VALUE and SHDN changes during a frame SHALL have no effect on that frame.
REQ-024 A LATCH edge detected in the same cycle BUSY falls SHALL be ignored. The earliest accepted start SHALL be one cycle after IDLE is re-entered.
REQ-025 CLK_DIV=1 SHALL still produce 16 full SCK cycles with 1-cycle high and low phases.

Reset
REQ-026 While RST_N=0, the block SHALL hold CS_DAC=1, CLK_DAC=0, SDI_DAC=0, LDAC_N=1, BUSY=0, state IDLE, all counters and the shift register at 0, and both edge-detect registers at 0.
REQ-027 Reset assertion mid-frame SHALL abort the frame immediately (asynchronously) without an LDAC pulse. After release, a new LATCH edge SHALL be required to start a frame.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the frame bit positions (AB=15, BUF=14, GA_N=13, SHDN_N=12) and FRAME_BITS=16.
REQ-029 A sub-module EDGE_DETECT (two-register rising-edge detector with async active-low reset) SHALL be used for LATCH and be reusable by other SPI blocks.

Verification
REQ-030 CLK_DIV=25, VALUE=12'hABC, SHDN=0, defaults, LATCH pulse -> SDI_DAC sampled at CLK_DAC rising edges = 16'h3ABC, exactly 16 rising edges.
REQ-031 Same frame -> CS_DAC low for 825 cycles, LDAC_N low for 25 cycles starting 50 cycles after the last falling edge, BUSY high 875 cycles.
REQ-032 SHDN=1, GAIN_1X=0, BUF=1, VALUE=12'h000 -> captured frame 16'h4000.
REQ-033 Second LATCH edge at t=10T with VALUE changed to 12'h123 -> first frame unchanged (16'h3ABC) and no second frame.
REQ-034 RST_N low at t=20T -> all outputs at reset values in the same cycle, no LDAC pulse; next LATCH after release sends a correct frame.
REQ-035 CLK_DIV=1, VALUE=12'hFFF -> frame 16'h3FFF, BUSY high 35 cycles.
